// File: rtl/pulse_delay_line.sv
// pulse_delay_line: multi-channel programmable pulse delay.
// Each channel's asynchronous input is synchronised, edge-detected into a
// one-cycle strobe, written every cycle into a circular buffer and replayed
// delay_active cycles later. The strobe is registered once before the buffer
// write and the buffer read lands directly in the output register, giving
// a fixed input-edge-to-output latency of D+3 cycles.

// Per-channel synchroniser and rising-edge detector.
module pdl_lane_sync (
  input  logic clk,
  input  logic rst,
  input  logic pulse_i,
  input  logic mask_i,
  output logic strobe_o
);
  // [0],[1] form the synchroniser; [2] holds the previous synchronised value.
  logic [2:0] sync_q;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], pulse_i};
  end

  assign strobe_o = sync_q[1] & ~sync_q[2] & mask_i;
endmodule

module pulse_delay_line #(
  parameter int CHANNELS      = 16,
  parameter int MAX_DELAY     = 256,
  parameter int DELAY_W       = $clog2(MAX_DELAY),
  parameter int DEFAULT_DELAY = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pulse_in,
  input  logic [CHANNELS-1:0] chan_mask,
  input  logic                enable,
  input  logic [DELAY_W-1:0]  cfg_delay,
  input  logic                cfg_load,
  output logic [CHANNELS-1:0] pulse_out,
  output logic                ready,
  output logic [DELAY_W-1:0]  delay_active
);
  localparam logic [DELAY_W-1:0] DLY_ONE = DELAY_W'(1);
  localparam logic [DELAY_W-1:0] DLY_RST = DELAY_W'(DEFAULT_DELAY);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [DELAY_W-1:0]   fill_q, fill_d;
  logic [DELAY_W-1:0]   dly_q, dly_d;
  logic [DELAY_W-1:0]   wr_ptr_q;
  logic [DELAY_W-1:0]   rd_addr;
  logic [CHANNELS-1:0]  strobe;
  logic [CHANNELS-1:0]  strobe_q;
  logic [CHANNELS-1:0]  pulse_q;
  logic [CHANNELS-1:0]  mem_q [MAX_DELAY];
  logic                 run_hold;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    pdl_lane_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .pulse_i  (pulse_in[g]),
      .mask_i   (chan_mask[g]),
      .strobe_o (strobe[g])
    );
  end

  // Next-state logic: enable low wins, cfg_load restarts the fill.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    dly_d   = dly_q;
    if (cfg_load) dly_d = (cfg_delay == '0) ? DLY_ONE : cfg_delay;
    if (!enable) begin
      state_d = S_IDLE;
      fill_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FILL;
          fill_d  = '0;
        end
        S_FILL: begin
          if (cfg_load) begin
            fill_d = '0;
          end else if (fill_q == dly_q - DLY_ONE) begin
            state_d = S_RUN;
            fill_d  = '0;
          end else begin
            fill_d = fill_q + DLY_ONE;
          end
        end
        S_RUN: begin
          if (cfg_load) begin
            state_d = S_FILL;
            fill_d  = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          fill_d  = '0;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      dly_q   <= DLY_RST;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      dly_q   <= dly_d;
    end
  end

  // Register the strobes so the buffer write is a clean flop-to-RAM path.
  always_ff @(posedge clk) begin
    if (rst) strobe_q <= '0;
    else     strobe_q <= strobe;
  end

  // Write pointer advances whenever the line is not idle.
  always_ff @(posedge clk) begin
    if (rst)                    wr_ptr_q <= '0;
    else if (state_q != S_IDLE) wr_ptr_q <= wr_ptr_q + DLY_ONE;
  end

  // Buffer write; no reset so the array maps onto block RAM. Stale data is
  // harmless because FILL lasts exactly delay_active cycles.
  always_ff @(posedge clk) begin
    if (state_q != S_IDLE) mem_q[wr_ptr_q] <= strobe_q;
  end

  assign rd_addr  = wr_ptr_q - dly_q;
  // Output only while staying in RUN, so disable/reload blank it at once.
  assign run_hold = (state_q == S_RUN) && (state_d == S_RUN);

  // Synchronous buffer read straight into the output register.
  always_ff @(posedge clk) begin
    if (rst)           pulse_q <= '0;
    else if (run_hold) pulse_q <= mem_q[rd_addr];
    else               pulse_q <= '0;
  end

  assign pulse_out    = pulse_q;
  assign ready        = (state_q == S_RUN);
  assign delay_active = dly_q;
endmodule
